dac_serial_out: RTL and testbench
=================================

Name: dac_serial_out

Overview:
- Output stage placed directly downstream of the 25-bit high-pass IIR filter.
- Accepts each filtered sample `y` on its one-cycle `rx_2` strobe and requantises it to a 12-bit DAC code (round, saturate, offset-binary).
- Shifts the code out as a 16-bit SPI frame (4 zero pad bits then 12 data bits, MSB first) to a DAC121S101-class converter.
- Provides a one-deep holding buffer so a new sample may arrive while the previous frame is still shifting.

Parameters:
- cant_bits, 25: width of the signed two's-complement input sample.
- dac_bits, 12: DAC code width; frame length is fixed at 16, so pad = 16 - dac_bits.
- clk_div, 4: `sclk` half-period in `clk` cycles, minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- y  in  cant_bits  filtered sample, signed two's complement.
- rx_2  in  1  one-cycle strobe; `y` is valid in the same cycle.
- sclk  out  1  serial clock to the DAC; idles high.
- sync_n  out  1  DAC frame select, active low.
- din  out  1  serial data; changes only on `sclk` rising edges.
- busy  out  1  high while a frame or its inter-frame gap is in progress.
- overrun  out  1  one-cycle pulse when a buffered sample is overwritten before use.

Behaviour:
- Reset (`rst`=0, asynchronous, including mid-frame):
  - outputs: `sclk`=1, `sync_n`=1, `din`=0, `busy`=0, `overrun`=0.
  - internal state: holding buffer empty, state IDLE, all counters 0.
- Capture:
  - On a clk edge with `rx_2`=1, `y` is written to `hold` and `hold_valid` is set.
  - If `hold_valid` was already set and is not being consumed on that same edge, the new sample overwrites the old one and `overrun`=1 for one cycle.
  - Capture and consume on the same edge: the old sample goes to the shifter, the new one lands in `hold`, no overrun.
- Requantisation (combinational, on `hold`):
  - t = y[24:13] (top `dac_bits`); r = y[12].
  - s = t + r, computed signed; if t = 0x7FF and r = 1, saturate to 0x7FF.
  - Negative values never overflow.
  - code = {~s[11], s[10:0]} (offset binary).
  - Frame word = {4'b0000, code}.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: `sclk`=1, `sync_n`=1, `busy`=0. If `hold_valid`: on the next edge load the shifter with the frame word, clear `hold_valid`, set `sync_n`=0, `din`=bit15, go to SHIFT.
    - Latency: `rx_2` sampled at edge N, `sync_n` falls at edge N+1, `hold_valid` is visible at edge N+1 with IDLE.
  - SHIFT:
    - A divider counts clk_div cycles; `sclk` toggles on each terminal count.
    - On each `sclk` falling toggle the DAC samples `din`; on the following rising toggle the shifter advances and `din` takes the next bit.
    - After the 16th falling edge plus clk_div cycles: `sclk`=1, `sync_n`=1, go to GAP.
    - SHIFT lasts exactly 32*clk_div cycles.
  - GAP: `sync_n` held high for 2*clk_div cycles (≥1 sclk period). Then go to IDLE; if `hold_valid`, start the next frame on the same edge, skipping idle.
- `busy` is 1 in SHIFT and GAP.
- Frame period is 34*clk_div cycles, i.e. 136 at the default.
- The `y` port is ignored when `rx_2`=0. `rx_2` held high for several cycles counts as repeated strobes.

Decomposition:
- Shared package `dac_pkg`:
  - FRAME_BITS=16, PAD_BITS=FRAME_BITS-dac_bits.
  - State encoding IDLE/SHIFT/GAP.
  - Default clk_div.
- One natural sub-module: `dac_formato`, combinational round/saturate/offset conversion (cant_bits in, dac_bits out). Verify it standalone.
- Top level holds the buffer, divider, bit counter, shifter and FSM.

Test Plan:
- Reset mid-frame: drive `rst`=0 at cycle 40 of a frame -> `sync_n`=1, `sclk`=1, `din`=0, `busy`=0 immediately (asynchronous); no frame resumes after release.
- y=25'h0000000 strobed in IDLE -> `sync_n` falls 1 edge later; serial word 0x0800; `sync_n` low for exactly 128 clk cycles; `busy` high for 136.
- y=25'h0FFFFFF -> 0x0FFF (saturated). y=25'h1000000 -> 0x0000. y=25'h0001000 -> 0x0801 (round up). y=25'h1FFEFFF -> 0x07FF (round 0x7FF.x down stays).
- Two strobes 10 cycles apart (A=0, B=25'h0800000) -> frame A 0x0800, then after the gap frame B 0x0C00 with no IDLE cycle; `overrun` never asserted.
- Three strobes within one frame (A, B, C) -> A sent, `overrun` pulses once on C's edge, C sent next, B never appears.
- Strobe arriving on the exact edge GAP exits with `hold_valid`=1 -> old sample shifts, new one is buffered, `overrun`=0.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serial output stage: frame geometry,
// FSM state encoding and default parameter values.
package dac_pkg;

    localparam int FRAME_BITS      = 16;
    localparam int DEF_CANT_BITS   = 25;
    localparam int DEF_DAC_BITS    = 12;
    localparam int DEF_CLK_DIV     = 4;
    localparam int PAD_BITS        = FRAME_BITS - DEF_DAC_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } dac_state_t;

endpackage

// File: rtl/dac_formato.sv
// Combinational requantiser: rounds a wide signed sample to the DAC width,
// saturates the single positive overflow case and converts to offset binary.
module dac_formato
    import dac_pkg::*;
#(
    parameter int cant_bits = DEF_CANT_BITS,
    parameter int dac_bits  = DEF_DAC_BITS
) (
    input  logic [cant_bits-1:0] i_y,
    output logic [dac_bits-1:0]  o_code
);

    localparam logic [dac_bits-1:0] MAX_POS = {1'b0, {(dac_bits-1){1'b1}}};

    logic [dac_bits-1:0] w_t;
    logic                w_r;
    logic [dac_bits-1:0] w_s;

    assign w_t = i_y[cant_bits-1 -: dac_bits];
    assign w_r = i_y[cant_bits-dac_bits-1];

    // Only the largest positive value can overflow when rounding up.
    always_comb begin
        w_s = w_t + {{(dac_bits-1){1'b0}}, w_r};
        if (w_r && (w_t == MAX_POS)) begin
            w_s = MAX_POS;
        end
    end

    assign o_code = {~w_s[dac_bits-1], w_s[dac_bits-2:0]};

endmodule

// File: rtl/dac_serial_out.sv
// SPI-style output stage for a DAC121S101-class converter: one-deep sample
// buffer, requantiser, clock divider and 16-bit MSB-first frame shifter.
module dac_serial_out
    import dac_pkg::*;
#(
    parameter int cant_bits = DEF_CANT_BITS,
    parameter int dac_bits  = DEF_DAC_BITS,
    parameter int clk_div   = DEF_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [cant_bits-1:0] y,
    input  logic                 rx_2,
    output logic                 sclk,
    output logic                 sync_n,
    output logic                 din,
    output logic                 busy,
    output logic                 overrun
);

    localparam int PAD   = FRAME_BITS - dac_bits;
    localparam int DIV_W = $clog2(2 * clk_div) + 1;
    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(clk_div - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(2 * clk_div - 1);
    localparam logic [4:0]       TOG_LAST  = 5'd31;

    dac_state_t r_state;
    dac_state_t w_nextState;
    logic                  w_load;
    logic [cant_bits-1:0]  r_hold;
    logic                  r_holdValid;
    logic                  r_overrun;
    logic [FRAME_BITS-1:0] r_shift;
    logic [DIV_W-1:0]      r_div;
    logic [4:0]            r_tog;
    logic                  r_sclk;
    logic [dac_bits-1:0]   w_code;
    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_tick;
    logic                  w_gapDone;

    dac_formato #(
        .cant_bits (cant_bits),
        .dac_bits  (dac_bits)
    ) u_formato (
        .i_y    (r_hold),
        .o_code (w_code)
    );

    assign w_frame   = {{PAD{1'b0}}, w_code};
    assign w_tick    = (r_div == TICK_LAST);
    assign w_gapDone = (r_div == GAP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A pending sample is consumed either from IDLE or directly at GAP exit.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_holdValid) begin
                    w_nextState = SHIFT;
                    w_load      = 1'b1;
                end
            end
            SHIFT: begin
                if (w_tick && (r_tog == TOG_LAST)) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (w_gapDone) begin
                    if (r_holdValid) begin
                        w_nextState = SHIFT;
                        w_load      = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_holdValid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= rx_2 && r_holdValid && !w_load;
            if (rx_2) begin
                r_hold      <= y;
                r_holdValid <= 1'b1;
            end else if (w_load) begin
                r_holdValid <= 1'b0;
            end
        end
    end

    // Shifter advances on rising sclk toggles so din is stable at each falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_div   <= '0;
            r_tog   <= '0;
            r_sclk  <= 1'b1;
        end else if (w_load) begin
            r_shift <= w_frame;
            r_div   <= '0;
            r_tog   <= '0;
            r_sclk  <= 1'b1;
        end else begin
            unique case (r_state)
                SHIFT: begin
                    if (w_tick) begin
                        r_div  <= '0;
                        r_tog  <= r_tog + 5'd1;
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                GAP: begin
                    r_div <= w_gapDone ? '0 : r_div + 1'b1;
                end
                default: begin
                    r_div <= '0;
                end
            endcase
        end
    end

    assign sclk    = r_sclk;
    assign sync_n  = (r_state != SHIFT);
    assign busy    = (r_state != IDLE);
    assign din     = (r_state == SHIFT) && r_shift[FRAME_BITS-1];
    assign overrun = r_overrun;

endmodule

// File: tb/tb_dac_serial_out.sv
// Scoreboard bench for dac_serial_out: a timing-level model predicts which
// samples are sent and when overrun fires; a monitor decodes the serial frames.
module tb_dac_serial_out;

    localparam int D      = 4;
    localparam int PERIOD = 34 * D;
    localparam int LOWLEN = 32 * D;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] y;
    logic        rx_2;
    logic        sclk, sync_n, din, busy, overrun;
    logic [24:0] fy;
    logic [11:0] fcode;

    int total = 0;
    int bad   = 0;

    logic [15:0] expQ[$];
    logic        pend;
    logic [24:0] pendY;
    longint      cyc;
    longint      nextStart;
    logic        expOv;
    int          ovCount;

    dac_serial_out #(.cant_bits(25), .dac_bits(12), .clk_div(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .y       (y),
        .rx_2    (rx_2),
        .sclk    (sclk),
        .sync_n  (sync_n),
        .din     (din),
        .busy    (busy),
        .overrun (overrun)
    );

    dac_formato #(.cant_bits(25), .dac_bits(12)) fmt (
        .i_y    (fy),
        .o_code (fcode)
    );

    always #5 clk = ~clk;

    // Round to nearest with arithmetic, clamp to the DAC range, shift to offset binary.
    function automatic logic [11:0] refCode(input logic [24:0] v);
        longint s;
        s = longint'($signed(v));
        s = (s + 4096) >>> 13;
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        return 12'(s + 2048);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [24:0] v);
        @(negedge clk);
        y    = v;
        rx_2 = 1'b1;
        @(negedge clk);
        rx_2 = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || pend || expQ.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) checkOutput("idle_timeout", 32'(n), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Reference model: a frame may start once the previous one plus its gap is over.
    initial begin
        pend = 1'b0; pendY = '0; cyc = 0; nextStart = 0; expOv = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                expQ.delete();
                pend = 1'b0;
                nextStart = 0;
                expOv = 1'b0;
            end else begin
                cyc++;
                expOv = 1'b0;
                if (pend && cyc >= nextStart) begin
                    expQ.push_back({4'b0000, refCode(pendY)});
                    pend = 1'b0;
                    nextStart = cyc + PERIOD;
                end
                if (rx_2) begin
                    if (pend) expOv = 1'b1;
                    pend  = 1'b1;
                    pendY = y;
                end
            end
        end
    end

    // Monitor: decode bits on sclk falling edges, check frame length and content.
    initial begin
        logic        prevSync, prevSclk;
        logic [15:0] word;
        int          bits, lowRun, busyRun;
        prevSync = 1'b1; prevSclk = 1'b1; word = '0; bits = 0; lowRun = 0; busyRun = 0;
        ovCount = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prevSync = 1'b1; prevSclk = 1'b1; bits = 0; lowRun = 0; busyRun = 0;
            end else begin
                checkOutput("overrun", 32'(overrun), 32'(expOv));
                if (overrun) ovCount++;
                if (prevSync && !sync_n) begin
                    word = '0; bits = 0; lowRun = 0;
                end
                if (!sync_n) begin
                    lowRun++;
                    if (prevSclk && !sclk) begin
                        word = {word[14:0], din};
                        bits++;
                    end
                end
                if (!prevSync && sync_n) begin
                    checkOutput("frame_bits", 32'(bits), 32'd16);
                    checkOutput("sync_low_len", 32'(lowRun), 32'(LOWLEN));
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_frame", 32'(word), 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("frame_word", 32'(word), 32'(expQ.pop_front()));
                    end
                end
                if (busy) begin
                    busyRun++;
                end else if (busyRun > 0) begin
                    checkOutput("busy_len_mod", 32'(busyRun % PERIOD), 32'd0);
                    busyRun = 0;
                end
                prevSync = sync_n;
                prevSclk = sclk;
            end
        end
    end

    initial begin
        logic [24:0] dirVals[5];
        int ov0, lowCnt, n;
        dirVals = '{25'h0000000, 25'h0FFFFFF, 25'h1000000, 25'h0001000, 25'h1FFEFFF};
        rst = 1'b0; rx_2 = 1'b0; y = '0; fy = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_sclk", 32'(sclk), 32'd1);
        checkOutput("rst_sync_n", 32'(sync_n), 32'd1);
        checkOutput("rst_din", 32'(din), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);

        fy = 25'h0FFFFFF; #1 checkOutput("fmt_sat", 32'(fcode), 32'h0FFF);
        fy = 25'h1000000; #1 checkOutput("fmt_min", 32'(fcode), 32'h0000);
        fy = 25'h0001000; #1 checkOutput("fmt_roundup", 32'(fcode), 32'h0801);
        fy = 25'h1FFEFFF; #1 checkOutput("fmt_neg_keep", 32'(fcode), 32'h07FF);
        for (int i = 0; i < 200; i++) begin
            fy = 25'($urandom);
            #1 checkOutput("fmt_rand", 32'(fcode), 32'(refCode(fy)));
        end

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(dirVals[i]);
            waitIdle();
        end

        ov0 = ovCount;
        applyStimulus(25'h0000000);
        repeat (8) @(negedge clk);
        applyStimulus(25'h0800000);
        waitIdle();
        checkOutput("pair_no_overrun", 32'(ovCount - ov0), 32'd0);

        ov0 = ovCount;
        applyStimulus(25'h0123456);
        repeat (5) @(negedge clk);
        applyStimulus(25'h1555555);
        repeat (10) @(negedge clk);
        applyStimulus(25'h0ABCDEF);
        waitIdle();
        checkOutput("triple_overrun_once", 32'(ovCount - ov0), 32'd1);

        // Third strobe lands exactly on the edge where the second frame starts.
        ov0 = ovCount;
        applyStimulus(25'h0200000);
        repeat (3) @(negedge clk);
        applyStimulus(25'h1E00000);
        repeat (130) @(negedge clk);
        applyStimulus(25'h0765432);
        waitIdle();
        checkOutput("gap_exit_no_overrun", 32'(ovCount - ov0), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rx_2 = ($urandom_range(0, 99) < 3);
            y    = 25'($urandom);
        end
        @(negedge clk);
        rx_2 = 1'b0;
        waitIdle();

        applyStimulus(25'h0F0F0F0);
        n = 0;
        while (sync_n && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) checkOutput("reset_frame_start_timeout", 32'(n), 32'd0);
        repeat (40) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_sync_n", 32'(sync_n), 32'd1);
        checkOutput("midrst_sclk", 32'(sclk), 32'd1);
        checkOutput("midrst_din", 32'(din), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        lowCnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!sync_n || busy) lowCnt++;
        end
        checkOutput("no_resume_after_reset", 32'(lowCnt), 32'd0);

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
